// File: rtl/proc_pkg.sv
// Shared constants and loader state encoding for the instruction-memory writer.
package proc_pkg;
    localparam int unsigned INSTR_W         = 19;
    localparam int unsigned IMEM_DEPTH      = 16384;
    localparam int unsigned IMEM_AW         = $clog2(IMEM_DEPTH);
    localparam int unsigned STREAM_W        = 8;
    localparam int unsigned BYTES_PER_INSTR = 3;
    localparam int unsigned BIDX_W          = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_WR,
        ST_DONE
    } ldr_state_e;
endpackage

// File: rtl/imem_word_packer.sv
// Packs a big-endian 3-byte group into one instruction word and flags
// first bytes that carry bits above the instruction's top field.
module imem_word_packer
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned BYTE_W = STREAM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              take,
    input  logic [BYTE_W-1:0] in_data,
    output logic [DATA_W-1:0] word_c,
    output logic              fmt_err
);
    localparam int unsigned HI_W = DATA_W - 2 * BYTE_W;

    logic [DATA_W-1:0] word_q, word_d;
    logic [BIDX_W-1:0] idx_q, idx_d;
    logic              fmt_err_q, fmt_err_d;
    logic              first;

    assign first = (idx_q == '0);

    // The first byte restarts the word; later bytes shift in below it.
    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        fmt_err_d = fmt_err_q;
        if (clr) begin
            word_d    = '0;
            idx_d     = '0;
            fmt_err_d = 1'b0;
        end else if (take) begin
            if (first) begin
                word_d = DATA_W'(in_data & BYTE_W'((1 << HI_W) - 1));
                if ((in_data >> HI_W) != '0) begin
                    fmt_err_d = 1'b1;
                end
            end else begin
                word_d = DATA_W'({word_q, in_data});
            end
            idx_d = (idx_q == BIDX_W'(BYTES_PER_INSTR - 1)) ? '0 : idx_q + BIDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q    <= '0;
            idx_q     <= '0;
            fmt_err_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            idx_q     <= idx_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    assign word_c  = word_d;
    assign fmt_err = fmt_err_q;
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs 3 bytes per word,
// writes consecutive addresses from 0 and holds the core while loading.
module imem_loader
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned ADDR_W = IMEM_AW,
    parameter int unsigned BYTE_W = STREAM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              fmt_err
);
    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_ok;
    logic              take;
    logic [DATA_W-1:0] word_c;

    assign start_ok = (state_q == ST_IDLE) && start;
    // Abort wins over a same-cycle byte, so the byte is not consumed.
    assign take     = in_ready_q && in_valid && !abort;

    imem_word_packer #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (start_ok),
        .take    (take),
        .in_data (in_data),
        .word_c  (word_c),
        .fmt_err (fmt_err)
    );

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        len_d       = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = len_m1;
                    addr_cnt_d = '0;
                    state_d    = ST_B0;
                end
            end
            ST_B0: if (abort) state_d = ST_IDLE; else if (take) state_d = ST_B1;
            ST_B1: if (abort) state_d = ST_IDLE; else if (take) state_d = ST_B2;
            ST_B2: if (abort) state_d = ST_IDLE; else if (take) state_d = ST_WR;
            ST_WR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (addr_cnt_q == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                    state_d    = ST_B0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs follow the state being entered.
        mem_we_d    = (state_d == ST_WR);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (mem_we_d) begin
            mem_addr_d  = addr_cnt_q;
            mem_wdata_d = word_c;
        end
        in_ready_d = (state_d == ST_B0) || (state_d == ST_B1) || (state_d == ST_B2);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_cnt_q  <= '0;
            len_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            len_q       <= len_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table, hand-written corner sequences and
// randomized loads checked against a byte-stream -> word-list model.
`timescale 1ns/1ps
module tb_imem_loader;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [13:0] len_m1 = '0;
    logic [7:0]  in_data = '0;
    logic        in_ready, mem_we, busy, cpu_hold, done, fmt_err;
    logic [13:0] mem_addr;
    logic [18:0] mem_wdata;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .len_m1(len_m1), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold),
        .done(done), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0, nerr = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int unsigned addr; int unsigned data; } wr_t;
    wr_t         exp_q[$];
    wr_t         mon_w;
    int unsigned mdl_word, mdl_nb, wr_cnt = 0, done_cnt = 0, last_we_cyc = 0, wr_in_load = 0;
    int unsigned last_we_addr = 0;
    logic [7:0]  mdl_part[3];
    bit          mdl_fmt = 0, spacing_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every 3 accepted bytes form word {b0[2:0], b1, b2} at the next address.
    function automatic void mdl_start();
        mdl_word = 0; mdl_nb = 0; mdl_fmt = 0; wr_in_load = 0;
    endfunction

    function automatic void mdl_byte(input logic [7:0] b);
        wr_t w;
        if (mdl_nb == 0 && b >= 8) mdl_fmt = 1;
        mdl_part[mdl_nb] = b;
        mdl_nb++;
        if (mdl_nb == 3) begin
            w.addr = mdl_word;
            w.data = (int'(mdl_part[0]) % 8) * 65536 + int'(mdl_part[1]) * 256 + int'(mdl_part[2]);
            exp_q.push_back(w);
            mdl_word++;
            mdl_nb = 0;
        end
    endfunction

    // Write/done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_w = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), mon_w.addr);
                check("wr_data", 32'(mem_wdata), mon_w.data);
                if (spacing_chk && wr_in_load > 0) check("wr_spacing", cyc - last_we_cyc, 4);
            end
            wr_cnt++; wr_in_load++; last_we_cyc = cyc; last_we_addr = 32'(mem_addr);
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_after_wr", cyc - last_we_cyc, 1);
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_start(input logic [13:0] len);
        mdl_start(); start = 1'b1; len_m1 = len; tick(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 0;
        for (int c = 0; c < 20 && !sent; c++) begin
            in_valid = 1'b1; in_data = b;
            if (in_ready) begin mdl_byte(b); sent = 1; end
            tick();
        end
        in_valid = 1'b0;
        if (!sent) begin nvec++; nerr++; $display("FAIL send_byte_timeout: in_ready stayed 0, expected 1"); end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_fmt_err"}, 32'(fmt_err), 0);
    endtask

    task automatic run_load(input int unsigned len, input int unsigned gap_pct,
                            input bit noise, input bit clean_fmt);
        logic [7:0]  bytes[$];
        int unsigned k = 0, wr0 = wr_cnt, d0 = done_cnt;
        bit          got_done = 0;
        for (int i = 0; i < 3 * (len + 1); i++)
            bytes.push_back((clean_fmt && i % 3 == 0) ? 8'($urandom_range(7)) : 8'($urandom));
        do_start(14'(len));
        for (int c = 0; c < 8 * 3 * (len + 1) + 20 && !got_done; c++) begin
            if (done === 1'b1) begin
                got_done = 1;
            end else begin
                in_valid = (k < bytes.size()) && ($urandom_range(99) >= gap_pct);
                in_data  = (k < bytes.size()) ? bytes[k] : 8'($urandom);
                start    = noise && ($urandom_range(9) == 0);
                len_m1   = 14'($urandom);
                if (in_valid && in_ready) begin mdl_byte(in_data); k++; end
                tick();
            end
        end
        in_valid = 1'b0; start = 1'b0;
        if (!got_done) begin nvec++; nerr++; $display("FAIL load_timeout: done not seen, expected done"); end
        check("load_writes", wr_cnt - wr0, len + 1);
        check("load_done_cnt", done_cnt - d0, 1);
        check("load_fmt_err", 32'(fmt_err), 32'(mdl_fmt));
        tick();
        check("load_busy_after", 32'(busy), 0);
        check("load_hold_after", 32'(cpu_hold), 0);
    endtask

    typedef struct { logic [7:0] b0, b1, b2; logic [18:0] wdata; logic fmt; } vec_t;
    vec_t tbl[6];

    initial begin
        int unsigned w0, d0;
        logic [7:0]  rb[3];

        #1 reset = 1'b1;
        repeat (3) tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Single-word loads with exact cycle timing.
        tbl[0] = '{8'h05, 8'hA5, 8'h3C, 19'h5A53C, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 8'h01, 19'h70001, 1'b1};
        tbl[2] = '{8'h07, 8'hFF, 8'hFF, 19'h7FFFF, 1'b0};
        tbl[3] = '{8'h08, 8'h00, 8'h00, 19'h00000, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 8'h00, 19'h00000, 1'b0};
        tbl[5] = '{8'h03, 8'h12, 8'h34, 19'h31234, 1'b0};
        for (int r = 0; r < 6; r++) begin
            spacing_chk = 0;
            rb[0] = tbl[r].b0; rb[1] = tbl[r].b1; rb[2] = tbl[r].b2;
            do_start(14'd0);
            check("row_busy", 32'(busy), 1);
            for (int b = 0; b < 3; b++) begin
                in_valid = 1'b1; in_data = rb[b]; mdl_byte(rb[b]); tick();
            end
            in_valid = 1'b0;
            check("row_we", 32'(mem_we), 1);
            check("row_addr", 32'(mem_addr), 0);
            check("row_wdata", 32'(mem_wdata), 32'(tbl[r].wdata));
            check("row_done_early", 32'(done), 0);
            tick();
            check("row_done", 32'(done), 1);
            check("row_busy_done", 32'(busy), 1);
            tick();
            check("row_done_off", 32'(done), 0);
            check("row_busy_off", 32'(busy), 0);
            check("row_hold_off", 32'(cpu_hold), 0);
            check("row_fmt", 32'(fmt_err), 32'(tbl[r].fmt));
        end

        // Three words, in_valid held high: writes 4 cycles apart.
        spacing_chk = 1;
        run_load(2, 0, 0, 1);
        check("three_fmt_clear", 32'(fmt_err), 0);
        spacing_chk = 0;

        // Backpressure gaps with ignored start pulses.
        run_load(1, 50, 1, 0);
        for (int r = 0; r < 4; r++) run_load($urandom_range(4), 40, 1, 0);

        // Abort after two bytes of word 1.
        w0 = wr_cnt; d0 = done_cnt;
        do_start(14'd3);
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
        send_byte(8'h02); send_byte(8'h33);
        abort = 1'b1; in_valid = 1'b1; in_data = 8'h77; tick();
        abort = 1'b0; in_valid = 1'b0; mdl_nb = 0;
        check("abort_busy", 32'(busy), 0);
        check("abort_hold", 32'(cpu_hold), 0);
        check("abort_ready", 32'(in_ready), 0);
        repeat (8) tick();
        check("abort_writes", wr_cnt - w0, 1);
        check("abort_no_done", done_cnt - d0, 0);

        // Abort coinciding with WR: that write still lands.
        w0 = wr_cnt; d0 = done_cnt;
        do_start(14'd5);
        send_byte(8'h06); send_byte(8'h9A); send_byte(8'hBC);
        check("abort_wr_we", 32'(mem_we), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_wr_busy", 32'(busy), 0);
        check("abort_wr_we_off", 32'(mem_we), 0);
        repeat (4) tick();
        check("abort_wr_writes", wr_cnt - w0, 1);
        check("abort_wr_no_done", done_cnt - d0, 0);

        // Asynchronous reset mid-word.
        d0 = done_cnt;
        do_start(14'd2);
        send_byte(8'hF9); send_byte(8'h12); send_byte(8'h34); send_byte(8'h05);
        check("prerst_fmt", 32'(fmt_err), 1);
        check("prerst_wdata", 32'(mem_wdata), 32'h11234);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_rst");
        tick(); tick();
        reset = 1'b0; mdl_start();
        repeat (4) tick();
        check("rst_no_done", done_cnt - d0, 0);

        // Full depth: 16384 words, no wrap afterwards.
        spacing_chk = 1;
        run_load(16383, 0, 0, 0);
        check("full_last_addr", last_we_addr, 16383);
        spacing_chk = 0;
        w0 = wr_cnt;
        repeat (20) tick();
        check("full_no_wrap", wr_cnt - w0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the 16K x 19-bit instruction memory that the fetch stage reads.
- Receives a byte stream over a valid/ready handshake and packs each group of 3 bytes into one 19-bit instruction.
- Writes the packed words to consecutive addresses starting at 0.
- Holds the core (cpu_hold) while loading; pulses done when the programmed word count has been written.

Parameters:
- DATA_W, 19, instruction width
- ADDR_W, 14, instruction memory address width (16384 words)
- BYTE_W, 8, input stream width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE
- len_m1  input  14  number of words to load minus 1; sampled when start is accepted
- abort  input  1  synchronous abort of a load in progress
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- mem_we  output  1  instruction memory write enable, registered
- mem_addr  output  14  instruction memory write address, registered
- mem_wdata  output  19  instruction memory write data, registered
- busy  output  1  load in progress (any state other than IDLE)
- cpu_hold  output  1  keep the core stalled/reset; equal to busy
- done  output  1  one-cycle pulse after the last word is written
- fmt_err  output  1  sticky: a first byte had nonzero bits [7:3]; cleared on accepted start

Behaviour:
- Reset (asynchronous): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, cpu_hold=0, done=0, fmt_err=0; word counter=0, byte shift register=0.
- Reset mid-load: memory words already written keep their values; no done pulse.
- States: IDLE, B0, B1, B2, WR, DONE.
- IDLE: start=1 latches len_m1, clears the address counter and fmt_err, then goes to B0. start in any other state is ignored.
- Byte handshake: a byte transfers when in_valid && in_ready. in_ready=1 only in B0/B1/B2 and does not depend combinationally on in_valid.
- Byte order is big-endian:
  - B0: byte supplies instr[18:16]=in_data[2:0]. If in_data[7:3]!=0, set fmt_err and discard those bits. Go to B1.
  - B1: byte supplies instr[15:8]. Go to B2.
  - B2: byte supplies instr[7:0]. Go to WR.
- WR (exactly 1 cycle): mem_we=1, mem_addr=addr_cnt, mem_wdata=assembled word; the memory captures at the end of this cycle.
  - If addr_cnt==len_m1, go to DONE.
  - Otherwise addr_cnt<=addr_cnt+1 and go to B0.
- The third byte accepted at edge N makes mem_we high from N to N+1. mem_we is 0 in every other state.
- Throughput: at most 1 word per 4 cycles when in_valid is held high.
- DONE: done=1 for one cycle, then IDLE. busy and cpu_hold drop in the same cycle the state returns to IDLE.
- len_m1=16383: addresses 0..16383 are written, then DONE. The counter never wraps because the comparison ends the load first.
- len_m1=0: exactly one word is loaded, at address 0.
- abort=1 in B0/B1/B2/WR: go to IDLE next cycle with no done pulse. If abort coincides with WR, that write still occurs this cycle. abort in IDLE/DONE is ignored.
- If in_valid and abort occur in the same cycle, abort wins and the byte is not consumed (in_ready=0 when aborting is not required; the byte is simply dropped).
- mem_addr and mem_wdata hold their last values outside WR.

Decomposition:
- Shared package (proc_pkg): INSTR_W=19, IMEM_AW=14, IMEM_DEPTH=16384, the loader state enum, and the byte-order constant (3 bytes per instruction).
- One sub-module, imem_word_packer: 3-byte shift/assemble register with a byte index and the fmt_err detect. The FSM and counters stay in imem_loader.

Test Plan:
- Single word: start with len_m1=0, stream 0x05,0xA5,0x3C → one mem_we pulse, addr=0, wdata=19'h5A53C; done pulses 1 cycle after WR; busy falls with it.
- Three words with in_valid held high: 9 bytes → writes at addr 0,1,2, spaced exactly 4 cycles apart; done after the addr-2 write; fmt_err=0.
- Format error: first byte 0xFF, then 0x00,0x01 → wdata=19'h70001, fmt_err=1 and stays set until the next accepted start.
- Backpressure gaps: random in_valid gaps in a 2-word load → no mem_we without a complete word; data and addresses correct; start pulses during the load are ignored.
- Abort/reset mid-word: abort after 2 bytes of word 1 → no write at addr 1, no done, busy=0 next cycle. Repeat with async reset → all outputs at reset values immediately.
- Full depth: len_m1=16383 with 49152 bytes → last write at addr 16383, done asserted, no write to addr 0 after wrap.
